// File: rtl/fe_pkg.sv
// Shared widths, FSM encoding and parameter defaults for the lag-1
// differential frequency-offset estimator.
package fe_pkg;

  localparam int NSAMP_DEF   = 64;
  localparam int W_DEF       = 9;
  localparam int LOG_BLK_DEF = 8;
  localparam int OUT_W_DEF   = 15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACQ   = 2'd1,
    ST_TRACK = 2'd2
  } fe_state_e;

  function automatic int prod_w(input int w);
    return 2 * w + 1;
  endfunction

  function automatic int sum_w(input int w, input int nsamp);
    return prod_w(w) + $clog2(nsamp);
  endfunction

  function automatic int acc_w(input int w, input int nsamp, input int log_blk);
    return sum_w(w, nsamp) + log_blk;
  endfunction

endpackage

// File: rtl/fe_diff_lane.sv
// One lane of the lag-1 differential product a*conj(b), registered on
// accepted beats.
module fe_diff_lane
  import fe_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic                        clk,
  input  logic                        rst_async,
  input  logic                        i_ce,
  input  logic signed [W-1:0]         i_ar,
  input  logic signed [W-1:0]         i_ai,
  input  logic signed [W-1:0]         i_br,
  input  logic signed [W-1:0]         i_bi,
  output logic signed [prod_w(W)-1:0] o_re,
  output logic signed [prod_w(W)-1:0] o_im
);

  localparam int PW = prod_w(W);

  logic signed [2*W-1:0] w_arbr, w_aibi, w_aibr, w_arbi;
  logic signed [PW-1:0]  w_re, w_im;

  assign w_arbr = i_ar * i_br;
  assign w_aibi = i_ai * i_bi;
  assign w_aibr = i_ai * i_br;
  assign w_arbi = i_ar * i_bi;
  assign w_re   = PW'(w_arbr) + PW'(w_aibi);
  assign w_im   = PW'(w_aibr) - PW'(w_arbi);

  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      o_re <= '0;
      o_im <= '0;
    end else if (i_ce) begin
      o_re <= w_re;
      o_im <= w_im;
    end
  end

endmodule

// File: rtl/fe_diff_est.sv
// Block-accumulated lag-1 differential frequency-offset estimator with a
// shift-coefficient IIR smoother; five-stage pipeline, one beat per cycle.
module fe_diff_est
  import fe_pkg::*;
#(
  parameter int NSAMP   = NSAMP_DEF,
  parameter int W       = W_DEF,
  parameter int LOG_BLK = LOG_BLK_DEF,
  parameter int OUT_W   = OUT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_async,
  input  logic                 i_enable,
  input  logic                 i_valid,
  input  logic                 i_subsampling,
  input  logic [3:0]           i_alpha,
  input  logic [NSAMP*W-1:0]   i_data_i,
  input  logic [NSAMP*W-1:0]   i_data_q,
  output logic                 o_fo_valid,
  output logic [OUT_W-1:0]     o_fo_re,
  output logic [OUT_W-1:0]     o_fo_im
);

  localparam int PROD_W = prod_w(W);
  localparam int SUM_W  = sum_w(W, NSAMP);
  localparam int ACC_W  = acc_w(W, NSAMP, LOG_BLK);

  fe_state_e r_fsm, w_fsm_nxt;
  logic w_load, w_upd;

  logic signed [W-1:0]      r_prev_i, r_prev_q;
  logic                     r_tog;
  logic [LOG_BLK-1:0]       r_cnt;
  logic                     w_accept, w_last;
  logic                     r_v1, r_last1, r_v2, r_last2, r_v3, r_v4;
  logic signed [PROD_W-1:0] w_lre [NSAMP];
  logic signed [PROD_W-1:0] w_lim [NSAMP];
  logic signed [SUM_W-1:0]  w_tree_re, w_tree_im, r_sum_re, r_sum_im;
  logic signed [ACC_W-1:0]  r_acc_re, r_acc_im, r_blk_re, r_blk_im;
  logic signed [ACC_W-1:0]  r_st_re, r_st_im;
  logic signed [ACC_W:0]    w_d_re, w_d_im, w_step_re, w_step_im;

  // Odd valid beats are skipped in subsampling mode (toggle=1 at that beat).
  assign w_accept = i_enable & i_valid & (~i_subsampling | ~r_tog);
  assign w_last   = (r_cnt == {LOG_BLK{1'b1}});

  for (genvar k = 0; k < NSAMP; k++) begin : g_lane
    logic signed [W-1:0] w_br, w_bi;
    if (k == 0) begin : g_first
      assign w_br = r_prev_i;
      assign w_bi = r_prev_q;
    end else begin : g_rest
      assign w_br = $signed(i_data_i[(k-1)*W +: W]);
      assign w_bi = $signed(i_data_q[(k-1)*W +: W]);
    end
    fe_diff_lane #(.W(W)) u_lane (
      .clk       (clk),
      .rst_async (rst_async),
      .i_ce      (w_accept),
      .i_ar      ($signed(i_data_i[k*W +: W])),
      .i_ai      ($signed(i_data_q[k*W +: W])),
      .i_br      (w_br),
      .i_bi      (w_bi),
      .o_re      (w_lre[k]),
      .o_im      (w_lim[k])
    );
  end

  always_comb begin
    w_tree_re = '0;
    w_tree_im = '0;
    for (int k = 0; k < NSAMP; k++) begin
      w_tree_re = w_tree_re + SUM_W'(w_lre[k]);
      w_tree_im = w_tree_im + SUM_W'(w_lim[k]);
    end
  end

  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      r_prev_i <= '0;
      r_prev_q <= '0;
      r_tog    <= 1'b0;
      r_cnt    <= '0;
      r_v1     <= 1'b0;
      r_last1  <= 1'b0;
      r_v2     <= 1'b0;
      r_last2  <= 1'b0;
      r_sum_re <= '0;
      r_sum_im <= '0;
    end else if (!i_enable) begin
      r_prev_i <= '0;
      r_prev_q <= '0;
      r_tog    <= 1'b0;
      r_cnt    <= '0;
      r_v1     <= 1'b0;
      r_last1  <= 1'b0;
      r_v2     <= 1'b0;
      r_last2  <= 1'b0;
    end else begin
      if (i_valid && i_subsampling) r_tog <= ~r_tog;
      if (w_accept) begin
        r_prev_i <= $signed(i_data_i[(NSAMP-1)*W +: W]);
        r_prev_q <= $signed(i_data_q[(NSAMP-1)*W +: W]);
        r_cnt    <= r_cnt + LOG_BLK'(1);
      end
      r_v1     <= w_accept;
      r_last1  <= w_accept & w_last;
      r_v2     <= r_v1;
      r_last2  <= r_last1;
      r_sum_re <= w_tree_re;
      r_sum_im <= w_tree_im;
    end
  end

  // The block total is handed off while the accumulator restarts from zero.
  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      r_acc_re <= '0;
      r_acc_im <= '0;
      r_blk_re <= '0;
      r_blk_im <= '0;
      r_v3     <= 1'b0;
    end else if (!i_enable) begin
      r_acc_re <= '0;
      r_acc_im <= '0;
      r_v3     <= 1'b0;
    end else begin
      r_v3 <= r_v2 & r_last2;
      if (r_v2 && r_last2) begin
        r_blk_re <= r_acc_re + ACC_W'(r_sum_re);
        r_blk_im <= r_acc_im + ACC_W'(r_sum_im);
        r_acc_re <= '0;
        r_acc_im <= '0;
      end else if (r_v2) begin
        r_acc_re <= r_acc_re + ACC_W'(r_sum_re);
        r_acc_im <= r_acc_im + ACC_W'(r_sum_im);
      end
    end
  end

  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) r_fsm <= ST_IDLE;
    else           r_fsm <= w_fsm_nxt;
  end

  always_comb begin
    w_fsm_nxt = r_fsm;
    w_load    = 1'b0;
    w_upd     = 1'b0;
    case (r_fsm)
      ST_IDLE: begin
        if (i_enable) w_fsm_nxt = ST_ACQ;
        else          w_fsm_nxt = ST_IDLE;
      end
      ST_ACQ: begin
        if (!i_enable) begin
          w_fsm_nxt = ST_IDLE;
        end else if (r_v3) begin
          w_fsm_nxt = ST_TRACK;
          w_load    = 1'b1;
        end else begin
          w_fsm_nxt = ST_ACQ;
        end
      end
      ST_TRACK: begin
        if (!i_enable) begin
          w_fsm_nxt = ST_IDLE;
        end else begin
          w_fsm_nxt = ST_TRACK;
          w_upd     = r_v3;
        end
      end
      default: w_fsm_nxt = ST_IDLE;
    endcase
  end

  assign w_d_re    = {r_blk_re[ACC_W-1], r_blk_re} - {r_st_re[ACC_W-1], r_st_re};
  assign w_d_im    = {r_blk_im[ACC_W-1], r_blk_im} - {r_st_im[ACC_W-1], r_st_im};
  assign w_step_re = w_d_re >>> i_alpha;
  assign w_step_im = w_d_im >>> i_alpha;

  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      r_st_re <= '0;
      r_st_im <= '0;
      r_v4    <= 1'b0;
    end else begin
      r_v4 <= w_load | w_upd;
      if (w_load) begin
        r_st_re <= r_blk_re;
        r_st_im <= r_blk_im;
      end else if (w_upd) begin
        r_st_re <= r_st_re + w_step_re[ACC_W-1:0];
        r_st_im <= r_st_im + w_step_im[ACC_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      o_fo_valid <= 1'b0;
      o_fo_re    <= '0;
      o_fo_im    <= '0;
    end else begin
      o_fo_valid <= r_v4 & i_enable;
      if (r_v4 && i_enable) begin
        o_fo_re <= r_st_re[ACC_W-1 -: OUT_W];
        o_fo_im <= r_st_im[ACC_W-1 -: OUT_W];
      end
    end
  end

endmodule

// File: tb/tb_fe_diff_est.sv
// Scoreboard bench for fe_diff_est: a block-level arithmetic model predicts
// each estimate and its arrival cycle; a monitor checks every output pulse.
module tb_fe_diff_est;

  localparam int NSAMP   = 64;
  localparam int W       = 9;
  localparam int LOG_BLK = 8;
  localparam int OUT_W   = 15;
  localparam int ACC_W   = 2 * W + 1 + $clog2(NSAMP) + LOG_BLK;
  localparam int BLK     = 1 << LOG_BLK;

  logic                 clk = 1'b0;
  logic                 rst_async;
  logic                 i_enable, i_valid, i_subsampling;
  logic [3:0]           i_alpha;
  logic [NSAMP*W-1:0]   i_data_i, i_data_q;
  logic                 o_fo_valid;
  logic [OUT_W-1:0]     o_fo_re, o_fo_im;

  fe_diff_est #(.NSAMP(NSAMP), .W(W), .LOG_BLK(LOG_BLK), .OUT_W(OUT_W)) dut (
    .clk           (clk),
    .rst_async     (rst_async),
    .i_enable      (i_enable),
    .i_valid       (i_valid),
    .i_subsampling (i_subsampling),
    .i_alpha       (i_alpha),
    .i_data_i      (i_data_i),
    .i_data_q      (i_data_q),
    .o_fo_valid    (o_fo_valid),
    .o_fo_re       (o_fo_re),
    .o_fo_im       (o_fo_im)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; longint re; longint im; } exp_t;
  exp_t exp_q[$];

  int n_chk = 0;
  int n_pass = 0;
  int n_push = 0;

  // Reference model state (block-level arithmetic)
  longint m_acc_re, m_acc_im, m_st_re, m_st_im, m_last_re, m_last_im;
  longint m_pi, m_pq;
  int     m_cnt;
  bit     m_tog, m_first;

  task automatic chk(input string name, input longint act, input longint expv);
    n_chk++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
  endtask

  function automatic longint lane(input logic [NSAMP*W-1:0] d, input int k);
    logic signed [W-1:0] s;
    s = d[k*W +: W];
    return longint'(s);
  endfunction

  function automatic longint tr(input longint s);
    logic signed [OUT_W-1:0] t;
    t = OUT_W'(s >>> (ACC_W - OUT_W));
    return longint'(t);
  endfunction

  function automatic logic [NSAMP*W-1:0] fill(input int v);
    logic [NSAMP*W-1:0] d;
    for (int k = 0; k < NSAMP; k++) d[k*W +: W] = W'(v);
    return d;
  endfunction

  function automatic logic [NSAMP*W-1:0] rnd_vec();
    logic [NSAMP*W-1:0] d;
    for (int k = 0; k < NSAMP; k++) d[k*W +: W] = W'($urandom);
    return d;
  endfunction

  function automatic logic [NSAMP*W-1:0] phase_vec(input int beat, input bit quad);
    logic [NSAMP*W-1:0] d;
    int ph, v;
    for (int k = 0; k < NSAMP; k++) begin
      ph = (beat * NSAMP + k) % 4;
      if (!quad) v = (ph == 0) ? 100 : (ph == 2) ? -100 : 0;
      else       v = (ph == 1) ? 100 : (ph == 3) ? -100 : 0;
      d[k*W +: W] = W'(v);
    end
    return d;
  endfunction

  task automatic model_clear();
    m_tog = 1'b0; m_cnt = 0; m_pi = 0; m_pq = 0;
    m_acc_re = 0; m_acc_im = 0; m_first = 1'b1;
  endtask

  task automatic model_step(input bit en, input bit v, input bit sub, input int al,
                            input logic [NSAMP*W-1:0] di, input logic [NSAMP*W-1:0] dq);
    longint sre, sim, ar, ai, br, bi;
    bit acc;
    exp_t e;
    if (!en) begin
      model_clear();
      return;
    end
    acc = v && (!sub || !m_tog);
    if (v && sub) m_tog = !m_tog;
    if (!acc) return;
    sre = 0; sim = 0;
    for (int k = 0; k < NSAMP; k++) begin
      ar = lane(di, k); ai = lane(dq, k);
      br = (k == 0) ? m_pi : lane(di, k - 1);
      bi = (k == 0) ? m_pq : lane(dq, k - 1);
      sre += ar * br + ai * bi;
      sim += ai * br - ar * bi;
    end
    m_pi = lane(di, NSAMP - 1);
    m_pq = lane(dq, NSAMP - 1);
    m_acc_re += sre;
    m_acc_im += sim;
    m_cnt++;
    if (m_cnt == BLK) begin
      if (m_first) begin
        m_st_re = m_acc_re;
        m_st_im = m_acc_im;
        m_first = 1'b0;
      end else begin
        m_st_re = m_st_re + ((m_acc_re - m_st_re) >>> al);
        m_st_im = m_st_im + ((m_acc_im - m_st_im) >>> al);
      end
      m_cnt = 0; m_acc_re = 0; m_acc_im = 0;
      e.cyc = cyc + 5; e.re = tr(m_st_re); e.im = tr(m_st_im);
      m_last_re = e.re; m_last_im = e.im;
      exp_q.push_back(e);
      n_push++;
    end
  endtask

  task automatic drive(input bit en, input bit v,
                       input logic [NSAMP*W-1:0] di, input logic [NSAMP*W-1:0] dq);
    @(posedge clk);
    #1;
    i_enable = en; i_valid = v; i_data_i = di; i_data_q = dq;
    model_step(en, v, i_subsampling, int'(i_alpha), di, dq);
  endtask

  task automatic idle(input bit en, input int n);
    for (int i = 0; i < n; i++) drive(en, 1'b0, rnd_vec(), rnd_vec());
  endtask

  // Monitor: every output pulse must match the oldest predicted estimate
  always @(negedge clk) begin
    exp_t e;
    if (!rst_async && o_fo_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("pulse_cycle", cyc, e.cyc);
        chk("fo_re", longint'($signed(o_fo_re)), e.re);
        chk("fo_im", longint'($signed(o_fo_im)), e.im);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int p0, guard;
    rst_async = 1'b1; i_enable = 1'b0; i_valid = 1'b0; i_subsampling = 1'b0;
    i_alpha = 4'd0; i_data_i = '0; i_data_q = '0;
    model_clear(); m_st_re = 0; m_st_im = 0; m_last_re = 0; m_last_im = 0;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_valid", longint'(o_fo_valid), 0);
    chk("reset_re", longint'($signed(o_fo_re)), 0);
    chk("reset_im", longint'($signed(o_fo_im)), 0);
    rst_async = 1'b0;

    // Constant (100,0), alpha 0
    for (int b = 0; b < BLK; b++) drive(1'b1, 1'b1, fill(100), fill(0));
    idle(1'b1, 8);

    // +90 degree phase stepping, two blocks after a fresh enable
    idle(1'b0, 2);
    for (int b = 0; b < 2 * BLK; b++) drive(1'b1, 1'b1, phase_vec(b, 1'b0), phase_vec(b, 1'b1));
    idle(1'b1, 8);

    // Subsampling: odd valid beats carry garbage
    idle(1'b0, 2);
    i_subsampling = 1'b1;
    for (int b = 0; b < 2 * BLK; b++) begin
      if (b % 2 == 0) drive(1'b1, 1'b1, fill(100), fill(0));
      else            drive(1'b1, 1'b1, rnd_vec(), rnd_vec());
    end
    idle(1'b1, 8);
    i_subsampling = 1'b0;

    // TRACK with alpha=1, block sums drop to zero
    i_alpha = 4'd1;
    for (int b = 0; b < 2 * BLK; b++) drive(1'b1, 1'b1, fill(0), fill(0));
    idle(1'b1, 8);

    // Random data, random valid gaps, alpha changed well inside each block
    p0 = n_push; guard = 0;
    while (n_push < p0 + 3 && guard < 4000) begin
      if (m_cnt == 100) i_alpha = 4'($urandom_range(0, 15));
      drive(1'b1, $urandom_range(0, 3) != 0, rnd_vec(), rnd_vec());
      guard++;
    end
    chk("random_blocks_done", longint'(n_push - p0), 3);
    idle(1'b1, 8);

    // Enable dropped at beat 100: no pulse, outputs held, fresh block after
    i_alpha = 4'd2;
    for (int b = 0; b < 100; b++) drive(1'b1, 1'b1, fill(-150), fill(50));
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, fill(-150), fill(50));
      chk("held_re", longint'($signed(o_fo_re)), m_last_re);
      chk("held_im", longint'($signed(o_fo_im)), m_last_im);
    end
    for (int b = 0; b < BLK; b++) drive(1'b1, 1'b1, fill(-150), fill(50));
    idle(1'b1, 8);

    // Asynchronous reset mid-block
    for (int b = 0; b < 50; b++) drive(1'b1, 1'b1, rnd_vec(), rnd_vec());
    @(posedge clk);
    #3 rst_async = 1'b1;
    #1;
    chk("async_rst_valid", longint'(o_fo_valid), 0);
    chk("async_rst_re", longint'($signed(o_fo_re)), 0);
    chk("async_rst_im", longint'($signed(o_fo_im)), 0);
    model_clear(); m_st_re = 0; m_st_im = 0; m_last_re = 0; m_last_im = 0;
    i_enable = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_async = 1'b0;
    idle(1'b0, 20);
    i_alpha = 4'd0;
    for (int b = 0; b < BLK; b++) drive(1'b1, 1'b1, fill(77), fill(-33));
    idle(1'b1, 10);

    chk("queue_drained", longint'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
